// File: rtl/scope_controller_if.sv
// Signal bundle between the scope controller and its UART, sampler and sample-memory neighbours.
interface scope_controller_if #(
  parameter int SAMPLE_DEPTH = 8
);
  logic                    rx_ready;
  logic [7:0]              rx_data;
  logic                    tx_active;
  logic                    tx_start;
  logic [7:0]              tx_data;
  logic                    smp_activate;
  logic                    smp_done;
  logic [SAMPLE_DEPTH-1:0] smp_offset;
  logic                    smp_tx_start;
  logic [7:0]              smp_tx_data;
  logic [15:0]             clk_div;
  logic [SAMPLE_DEPTH-1:0] rd_addr;
  logic [7:0]              rd_data;
  logic                    busy;

  modport master (
    input  rx_ready, rx_data, tx_active, smp_done, smp_offset,
           smp_tx_start, smp_tx_data, rd_data,
    output tx_start, tx_data, smp_activate, clk_div, rd_addr, busy
  );

  modport slave (
    output rx_ready, rx_data, tx_active, smp_done, smp_offset,
           smp_tx_start, smp_tx_data, rd_data,
    input  tx_start, tx_data, smp_activate, clk_div, rd_addr, busy
  );
endinterface

// File: rtl/scope_controller.sv
// Command sequencer for the sampling path: parses UART commands, arms the sampler,
// shares the transmitter with it and streams the circular capture buffer oldest-first.
module scope_controller #(
  parameter int          SAMPLE_DEPTH = 8,
  parameter logic [15:0] DEFAULT_DIV  = 16'd50,
  parameter int          ARG_TIMEOUT  = 20
) (
  input  logic                  clk_50mhz,
  input  logic                  reset,
  scope_controller_if.master    bus
);

  localparam logic [7:0] CMD_SET_DIV = 8'h01;
  localparam logic [7:0] CMD_ARM     = 8'h02;
  localparam logic [7:0] CMD_READ    = 8'h03;
  localparam logic [7:0] CMD_STATUS  = 8'h04;
  localparam logic [7:0] FRAME_HDR   = 8'hA5;
  localparam logic [7:0] NO_CAPTURE  = 8'hEE;

  localparam logic [SAMPLE_DEPTH-1:0] HALF_DEPTH = {1'b1, {(SAMPLE_DEPTH-1){1'b0}}};
  localparam logic [SAMPLE_DEPTH:0]   FRAME_LEN  = {1'b1, {SAMPLE_DEPTH{1'b0}}};
  localparam logic [SAMPLE_DEPTH-1:0] ADDR_ONE   = SAMPLE_DEPTH'(1);
  localparam logic [SAMPLE_DEPTH:0]   CNT_ONE    = (SAMPLE_DEPTH+1)'(1);
  localparam logic [ARG_TIMEOUT-1:0]  TMO_ONE    = ARG_TIMEOUT'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_DIV_HI, S_DIV_LO, S_CAPTURE, S_RELEASE,
    S_RD_ADDR, S_RD_DATA, S_TX_START, S_TX_WAIT_HI, S_TX_WAIT_LO
  } state_t;

  state_t                  state;
  logic [15:0]             clk_div_r;
  logic [7:0]              div_hi;
  logic [ARG_TIMEOUT-1:0]  tmo_cnt;
  logic                    have_capture;
  logic                    dropped;
  logic                    frame;
  logic [SAMPLE_DEPTH-1:0] trig_addr;
  logic [SAMPLE_DEPTH-1:0] rd_addr_r;
  logic [SAMPLE_DEPTH:0]   byte_cnt;
  logic                    tx_start_r;
  logic [7:0]              tx_data_r;
  logic                    smp_activate_r;
  logic                    sampler_owns_tx;
  logic                    tmo_sat;
  logic                    rx_is_dropped;

  // A zero divisor would stall the sampler clock, so it is promoted to 1.
  function automatic logic [15:0] sanitize_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

  assign sampler_owns_tx = (state == S_CAPTURE) || (state == S_RELEASE);
  assign tmo_sat         = &tmo_cnt;
  assign rx_is_dropped   = bus.rx_ready && !(state inside {S_IDLE, S_DIV_HI, S_DIV_LO, S_CAPTURE});

  assign bus.tx_start     = sampler_owns_tx ? bus.smp_tx_start : tx_start_r;
  assign bus.tx_data      = sampler_owns_tx ? bus.smp_tx_data  : tx_data_r;
  assign bus.smp_activate = smp_activate_r;
  assign bus.clk_div      = clk_div_r;
  assign bus.rd_addr      = rd_addr_r;
  assign bus.busy         = (state != S_IDLE);

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      clk_div_r      <= DEFAULT_DIV;
      div_hi         <= 8'h00;
      tmo_cnt        <= '0;
      have_capture   <= 1'b0;
      dropped        <= 1'b0;
      frame          <= 1'b0;
      trig_addr      <= '0;
      rd_addr_r      <= '0;
      byte_cnt       <= '0;
      tx_start_r     <= 1'b0;
      tx_data_r      <= 8'h00;
      smp_activate_r <= 1'b0;
    end else begin
      if (rx_is_dropped) dropped <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (bus.rx_ready) begin
            unique case (bus.rx_data)
              CMD_SET_DIV: begin
                tmo_cnt <= '0;
                state   <= S_DIV_HI;
              end
              CMD_ARM: begin
                smp_activate_r <= 1'b1;
                state          <= S_CAPTURE;
              end
              CMD_READ: begin
                if (have_capture) begin
                  frame     <= 1'b1;
                  byte_cnt  <= '0;
                  rd_addr_r <= trig_addr + HALF_DEPTH;
                  tx_data_r <= FRAME_HDR;
                end else begin
                  frame     <= 1'b0;
                  tx_data_r <= NO_CAPTURE;
                end
                state <= S_TX_START;
              end
              CMD_STATUS: begin
                frame     <= 1'b0;
                tx_data_r <= {6'b0, dropped, have_capture};
                dropped   <= 1'b0;
                state     <= S_TX_START;
              end
              default: state <= S_IDLE;
            endcase
          end
        end

        S_DIV_HI: begin
          if (bus.rx_ready) begin
            div_hi  <= bus.rx_data;
            tmo_cnt <= '0;
            state   <= S_DIV_LO;
          end else if (tmo_sat) begin
            dropped <= 1'b1;
            state   <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end

        S_DIV_LO: begin
          if (bus.rx_ready) begin
            clk_div_r <= sanitize_div({div_hi, bus.rx_data});
            tmo_cnt   <= '0;
            state     <= S_IDLE;
          end else if (tmo_sat) begin
            dropped <= 1'b1;
            state   <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end

        // Bytes arriving here belong to the sampler; done takes priority over them.
        S_CAPTURE: begin
          if (bus.smp_done) begin
            trig_addr      <= bus.smp_offset;
            have_capture   <= 1'b1;
            smp_activate_r <= 1'b0;
            state          <= S_RELEASE;
          end
        end

        S_RELEASE: begin
          if (!bus.smp_done && !bus.tx_active) begin
            frame     <= 1'b1;
            byte_cnt  <= '0;
            rd_addr_r <= trig_addr + HALF_DEPTH;
            tx_data_r <= FRAME_HDR;
            state     <= S_TX_START;
          end
        end

        S_RD_ADDR: state <= S_RD_DATA;

        S_RD_DATA: begin
          tx_data_r <= bus.rd_data;
          rd_addr_r <= rd_addr_r + ADDR_ONE;
          byte_cnt  <= byte_cnt + CNT_ONE;
          state     <= S_TX_START;
        end

        S_TX_START: begin
          if (!bus.tx_active) begin
            tx_start_r <= 1'b1;
            state      <= S_TX_WAIT_HI;
          end
        end

        S_TX_WAIT_HI: begin
          tx_start_r <= 1'b0;
          if (bus.tx_active) state <= S_TX_WAIT_LO;
        end

        S_TX_WAIT_LO: begin
          if (!bus.tx_active)
            state <= (frame && (byte_cnt != FRAME_LEN)) ? S_RD_ADDR : S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scope_controller.sv
// Directed bench for scope_controller with UART, sampler and memory models and a byte-stream scoreboard.
module tb_scope_controller;

  localparam int SD = 8;
  localparam int N  = 1 << SD;

  logic clk_50mhz = 1'b0;
  logic reset     = 1'b0;
  always #10 clk_50mhz = ~clk_50mhz;

  scope_controller_if #(.SAMPLE_DEPTH(SD)) bus ();

  scope_controller #(
    .SAMPLE_DEPTH(SD),
    .DEFAULT_DIV (16'd50),
    .ARG_TIMEOUT (6)
  ) dut (
    .clk_50mhz(clk_50mhz),
    .reset    (reset),
    .bus      (bus)
  );

  logic [7:0] mem [N];
  logic [7:0] exp_q [$];
  logic [7:0] got_log [$];
  logic [7:0] first_frame [$];
  int n_cmp = 0;
  int n_bad = 0;
  bit prev_start = 1'b0;
  int uart_cnt = 0;

  bit         m_have_cap = 1'b0;
  bit         m_dropped  = 1'b0;
  logic [7:0] m_trig     = 8'h00;

  // Sample memory, one-cycle registered read
  always @(posedge clk_50mhz) bus.rd_data <= mem[bus.rd_addr];

  // UART transmitter: busy from the cycle after a start for four cycles
  always @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      bus.tx_active <= 1'b0;
      uart_cnt      <= 0;
    end else if (bus.tx_active) begin
      if (uart_cnt == 0) bus.tx_active <= 1'b0;
      else uart_cnt <= uart_cnt - 1;
    end else if (bus.tx_start) begin
      bus.tx_active <= 1'b1;
      uart_cnt      <= 3;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every transmitted byte must be the next one the model predicts
  always @(negedge clk_50mhz) begin
    if (reset) begin
      if (bus.tx_start) begin
        if (prev_start) begin
          n_cmp++; n_bad++;
          $display("FAIL tx_pulse_width: tx_start high for 2+ cycles, data %0h", bus.tx_data);
        end else begin
          got_log.push_back(bus.tx_data);
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL tx_unexpected: got byte %0h, expected none", bus.tx_data);
          end else begin
            check("tx_byte", bus.tx_data, exp_q.pop_front());
          end
        end
      end
      prev_start = bus.tx_start;
    end else begin
      prev_start = 1'b0;
    end
  end

  function automatic void push_frame();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < N; i++) exp_q.push_back(mem[8'(int'(m_trig) + N/2 + i)]);
  endfunction

  function automatic void push_read();
    if (m_have_cap) push_frame();
    else exp_q.push_back(8'hEE);
  endfunction

  function automatic void push_status();
    exp_q.push_back({6'b0, m_dropped, m_have_cap});
    m_dropped = 1'b0;
  endfunction

  task automatic send_rx(input logic [7:0] b);
    @(posedge clk_50mhz); #1;
    bus.rx_ready = 1'b1;
    bus.rx_data  = b;
    @(posedge clk_50mhz); #1;
    bus.rx_ready = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (bus.busy && k < budget) begin
      @(posedge clk_50mhz); #1;
      k++;
    end
    check(name, bus.busy, 0);
  endtask

  task automatic wait_log(input string name, input int n, input int budget);
    int k = 0;
    while (got_log.size() < n && k < budget) begin
      @(posedge clk_50mhz); #1;
      k++;
    end
    check(name, (got_log.size() >= n), 1);
  endtask

  initial begin
    int base;
    int diffs;
    for (int i = 0; i < N; i++) mem[i] = 8'(i);
    bus.rx_ready     = 1'b0;
    bus.rx_data      = 8'h00;
    bus.smp_done     = 1'b0;
    bus.smp_offset   = '0;
    bus.smp_tx_start = 1'b0;
    bus.smp_tx_data  = 8'h00;

    repeat (3) @(posedge clk_50mhz);
    #1;
    check("rst_clk_div", bus.clk_div, 16'd50);
    check("rst_busy", bus.busy, 0);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_smp_activate", bus.smp_activate, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    @(negedge clk_50mhz) reset = 1'b1;

    // Divisor write
    send_rx(8'h01);
    check("div_busy", bus.busy, 1);
    send_rx(8'h12);
    check("div_hold_after_hi", bus.clk_div, 16'd50);
    send_rx(8'h34);
    check("div_1234", bus.clk_div, 16'h1234);
    check("div_idle", bus.busy, 0);

    send_rx(8'h01); send_rx(8'h00); send_rx(8'h00);
    check("div_zero_to_one", bus.clk_div, 16'd1);

    // Argument timeout
    send_rx(8'h01); send_rx(8'h12);
    repeat (100) @(posedge clk_50mhz);
    #1;
    check("tmo_idle", bus.busy, 0);
    check("tmo_div_unchanged", bus.clk_div, 16'd1);
    m_dropped = 1'b1;
    send_rx(8'h04);
    push_status();
    wait_idle("status_done", 200);
    check("status_after_tmo", got_log[got_log.size()-1], 8'h02);
    check("status_q_empty", exp_q.size(), 0);

    // READ without a capture
    send_rx(8'h03);
    push_read();
    wait_idle("read_nocap_done", 200);
    check("read_nocap_byte", got_log[got_log.size()-1], 8'hEE);
    check("read_nocap_q_empty", exp_q.size(), 0);

    // ARM, sampler traffic during CAPTURE, then done
    send_rx(8'h02);
    check("arm_activate", bus.smp_activate, 1);
    check("arm_busy", bus.busy, 1);
    @(posedge clk_50mhz); #1;
    exp_q.push_back(8'h55);
    bus.smp_tx_start = 1'b1;
    bus.smp_tx_data  = 8'h55;
    #1;
    check("pass_tx_start", bus.tx_start, 1);
    check("pass_tx_data", bus.tx_data, 8'h55);
    @(posedge clk_50mhz); #1;
    bus.smp_tx_start = 1'b0;
    send_rx(8'h55);
    @(posedge clk_50mhz); #1;
    bus.smp_done   = 1'b1;
    bus.smp_offset = 8'h10;
    bus.rx_ready   = 1'b1;
    bus.rx_data    = 8'h04;
    m_trig     = 8'h10;
    m_have_cap = 1'b1;
    push_frame();
    @(posedge clk_50mhz); #1;
    bus.rx_ready = 1'b0;
    check("done_deactivate", bus.smp_activate, 0);
    base = got_log.size();
    repeat (2) @(posedge clk_50mhz);
    #1;
    bus.smp_done = 1'b0;
    wait_idle("frame_done", 6000);
    check("frame_q_empty", exp_q.size(), 0);
    check("frame_len", got_log.size() - base, 257);
    if (got_log.size() - base == 257) begin
      check("frame_hdr", got_log[base], 8'hA5);
      check("frame_first", got_log[base+1], 8'h90);
      check("frame_ff", got_log[base+112], 8'hFF);
      check("frame_wrap", got_log[base+113], 8'h00);
      check("frame_last", got_log[base+256], 8'h8F);
      for (int i = 0; i < 257; i++) first_frame.push_back(got_log[base+i]);
    end

    send_rx(8'h04);
    push_status();
    wait_idle("status2_done", 200);
    check("status_after_cap", got_log[got_log.size()-1], 8'h01);

    // Re-read the same capture
    base = got_log.size();
    send_rx(8'h03);
    push_read();
    wait_idle("reread_done", 6000);
    check("reread_q_empty", exp_q.size(), 0);
    check("reread_len", got_log.size() - base, 257);
    diffs = 0;
    if (first_frame.size() == 257 && got_log.size() - base == 257)
      for (int i = 0; i < 257; i++) if (got_log[base+i] !== first_frame[i]) diffs++;
    check("reread_identical", diffs, 0);

    // Reset in the middle of a readout
    base = got_log.size();
    send_rx(8'h03);
    push_read();
    wait_log("abort_reach_100", base + 101, 3000);
    @(posedge clk_50mhz); #5;
    reset = 1'b0;
    exp_q.delete();
    m_have_cap = 1'b0;
    m_dropped  = 1'b0;
    #1;
    check("abort_tx_start", bus.tx_start, 0);
    check("abort_tx_data", bus.tx_data, 8'h00);
    check("abort_smp_activate", bus.smp_activate, 0);
    check("abort_clk_div", bus.clk_div, 16'd50);
    check("abort_rd_addr", bus.rd_addr, 0);
    check("abort_busy", bus.busy, 0);
    @(negedge clk_50mhz) reset = 1'b1;
    repeat (8) @(posedge clk_50mhz);
    send_rx(8'h03);
    push_read();
    wait_idle("post_reset_read_done", 200);
    check("post_reset_read", got_log[got_log.size()-1], 8'hEE);
    check("post_reset_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
